// File: rtl/weight_store_n_pkg.sv
// -----------------------------------------------------------------------------
// weight_store_n_pkg
// Shared definitions for the parametrised weight store:
//   - layer state codes driven on cs by the network sequencer
//   - default weight word width
//   - fill FSM state encoding
//   - cs -> layer-slice index decode with an invalid flag
// -----------------------------------------------------------------------------
package weight_store_n_pkg;

  // Layer state codes seen on cs. Code 0 is the sequencer's idle state and is
  // also the value the delayed copy of cs takes after reset.
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_LAYER0 = 4'd1;
  localparam logic [3:0] ST_LAYER1 = 4'd2;
  localparam logic [3:0] ST_LAYER2 = 4'd3;
  localparam logic [3:0] ST_LAYER3 = 4'd4;
  localparam logic [3:0] ST_AFFINE = 4'd5;

  // Default bits per weight word.
  localparam int DATA_LEN_DEF = 16;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_FILL,
    FS_DONE
  } fill_state_t;

  // Result of decoding a state code: which slice, and whether the code names
  // a slice at all.
  typedef struct packed {
    logic       ok;
    logic [2:0] idx;
  } layer_sel_t;

  // LAYER0..LAYER3 map to slices 0..3 and AFFINE maps to slice 4; every other
  // code is reported as not ok with a zero index so nothing downstream sees X.
  function automatic layer_sel_t cs_to_layer(input logic [3:0] cs);
    layer_sel_t sel;
    sel.ok  = 1'b1;
    sel.idx = 3'd0;
    case (cs)
      ST_LAYER0: sel.idx = 3'd0;
      ST_LAYER1: sel.idx = 3'd1;
      ST_LAYER2: sel.idx = 3'd2;
      ST_LAYER3: sel.idx = 3'd3;
      ST_AFFINE: sel.idx = 3'd4;
      default:   sel.ok  = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/weight_store_n_rom.sv
// -----------------------------------------------------------------------------
// w_rom_n
// Synchronous weight ROM holding all layer slices back to back.
// The read is registered and then delayed so that data for the address
// presented before edge e appears on q after edge e + ROM_LAT - 1.
// The ROM returns its own address (bring-up pattern); FILENAME is kept as a
// parameter so the interface matches the store that instantiates it.
//
// Ports:
//   clk   in   1         read clock, rising edge
//   addr  in   ADDR_W    word address
//   q     out  DATA_LEN  read data, ROM_LAT cycles after addr
// -----------------------------------------------------------------------------
module w_rom_n #(
  parameter string FILENAME = "",
  parameter int    DATA_LEN = 16,
  parameter int    ADDR_W   = 11,
  parameter int    ROM_LAT  = 1
) (
  input  logic                clk,
  input  logic [ADDR_W-1:0]   addr,
  output logic [DATA_LEN-1:0] q
);

  logic [DATA_LEN-1:0] rd_word;
  logic [DATA_LEN-1:0] pipe [ROM_LAT];

  assign rd_word = DATA_LEN'(addr);

  // NOTE: read-data stages carry no reset so they map onto block-RAM output
  // registers; nothing consumes them until a strobe says the data is live.
  // Non-blocking assignments make every stage sample the previous stage's old
  // value, which is what turns this loop into a shift register.
  always_ff @(posedge clk) begin
    pipe[0] <= rd_word;
    for (int i = 1; i < ROM_LAT; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[ROM_LAT-1];

endmodule

// File: rtl/weight_store_n.sv
// -----------------------------------------------------------------------------
// weight_store_n
// Streams one layer's weight slice from the weight ROM into a flat register
// bank whenever the layer state changes or a reload is requested, then
// presents the whole bank as one wide bus to the conv/affine datapath.
//
// Ports:
//   clk     in   1                  system clock, rising edge
//   rst_n   in   1                  asynchronous active-low reset
//   cs      in   4                  current layer state code
//   reload  in   1                  single-cycle pulse, re-fetch current slice
//   busy    out  1                  a fill is in progress
//   valid   out  1                  q holds the complete slice for cs
//   q       out  N_WORDS*DATA_LEN   word i at q[i*DATA_LEN +: DATA_LEN]
//
// Timing: a trigger at edge k writes word i at edge k+1+ROM_LAT+i and raises
// valid at edge k+ROM_LAT+N_WORDS. A new trigger always wins over whatever the
// FSM was doing, including the completing write.
// -----------------------------------------------------------------------------
module weight_store_n
  import weight_store_n_pkg::*;
#(
  parameter string FILENAME = "../data/data18/weight18_0.txt",
  parameter int    DATA_LEN = DATA_LEN_DEF,
  parameter int    N_WORDS  = 288,
  parameter int    N_LAYERS = 5,
  parameter int    ROM_LAT  = 1,
  parameter int    ADDR_W   = 11
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  cs,
  input  logic                        reload,
  output logic                        busy,
  output logic                        valid,
  output logic [N_WORDS*DATA_LEN-1:0] q
);

  localparam int CNT_W  = $clog2(N_WORDS + 1);
  localparam int WIDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  fill_state_t         state;
  logic [3:0]          cs_d;
  logic [ADDR_W-1:0]   addr;
  logic [CNT_W-1:0]    issue_cnt;
  logic [WIDX_W-1:0]   wr_idx;
  logic [ROM_LAT-1:0]  strobe_pipe;
  logic [DATA_LEN-1:0] rom_q;
  logic [DATA_LEN-1:0] bank [N_WORDS];

  layer_sel_t          sel;
  logic                sel_ok;
  logic [ADDR_W-1:0]   base;
  logic                trigger;
  logic                issuing;
  logic                wr_en;
  logic                wr_last;

  // ---------------------------------------------------------------------------
  // Decode and control terms
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a value before any branch, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    sel     = cs_to_layer(cs);
    sel_ok  = sel.ok && (int'(sel.idx) < N_LAYERS);
    base    = ADDR_W'(int'(sel.idx) * N_WORDS);
    trigger = (cs != cs_d) || reload;
    issuing = (state == FS_FILL) && (issue_cnt < CNT_W'(N_WORDS));
    // A write scheduled for the same edge as a trigger belongs to the fill
    // being abandoned, so it is dropped.
    wr_en   = (state == FS_FILL) && strobe_pipe[ROM_LAT-1] && !trigger;
    wr_last = (wr_idx == WIDX_W'(N_WORDS - 1));
  end

  // ---------------------------------------------------------------------------
  // Fill FSM, address/issue counters and strobe pipe
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FS_IDLE;
      cs_d        <= ST_IDLE;
      addr        <= '0;
      issue_cnt   <= '0;
      wr_idx      <= '0;
      strobe_pipe <= '0;
      busy        <= 1'b0;
      valid       <= 1'b0;
    end else begin
      cs_d <= cs;

      if (trigger) begin
        // Flushing the strobes is what keeps reads issued for the old slice
        // from landing in the bank after a restart.
        strobe_pipe <= '0;
        valid       <= 1'b0;
        if (sel_ok) begin
          state     <= FS_FILL;
          addr      <= base;
          issue_cnt <= '0;
          wr_idx    <= '0;
          busy      <= 1'b1;
        end else begin
          // Unknown code: park with the ROM address held where it was.
          state     <= FS_IDLE;
          busy      <= 1'b0;
        end
      end else if (state == FS_FILL) begin
        strobe_pipe <= (strobe_pipe << 1) | ROM_LAT'(issuing);

        if (issuing) begin
          issue_cnt <= issue_cnt + 1'b1;
          // The last issued address is held rather than stepped, so addr
          // never points into the neighbouring slice.
          if (issue_cnt != CNT_W'(N_WORDS - 1)) begin
            addr <= addr + 1'b1;
          end
        end

        if (wr_en) begin
          wr_idx <= wr_idx + 1'b1;
          if (wr_last) begin
            state <= FS_DONE;
            valid <= 1'b1;
            busy  <= 1'b0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Weight bank: written only from the fill path, never reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank[wr_idx] <= rom_q;
    end
  end

  generate
    for (genvar i = 0; i < N_WORDS; i++) begin : g_flat
      assign q[i*DATA_LEN +: DATA_LEN] = bank[i];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Weight ROM
  // ---------------------------------------------------------------------------
  w_rom_n #(
    .FILENAME (FILENAME),
    .DATA_LEN (DATA_LEN),
    .ADDR_W   (ADDR_W),
    .ROM_LAT  (ROM_LAT)
  ) u_rom (
    .clk  (clk),
    .addr (addr),
    .q    (rom_q)
  );

endmodule

// File: tb/tb_weight_store_n.sv
// -----------------------------------------------------------------------------
// tb_weight_store_n
// Two instances share clock and reset: a small one (4 words, ROM latency 2)
// for the table of layer fills and the multi-cycle corner cases, and one with
// default geometry for full-length latency and end-of-slice addresses. Both
// use the address-as-data ROM pattern, so word i of slice L reads L*N+i.
// -----------------------------------------------------------------------------
module tb_weight_store_n;
  import weight_store_n_pkg::*;

  localparam int DL       = 16;
  localparam int SN       = 4;
  localparam int SLAT     = 2;
  localparam int S_LATENCY = SLAT + SN;     // 6
  localparam int DN       = 288;
  localparam int D_LATENCY = 1 + DN;        // 289

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     cs_s, cs_d;
  logic           reload_s, reload_d;
  logic           busy_s, valid_s, busy_d, valid_d;
  logic [SN*DL-1:0] q_s;
  logic [DN*DL-1:0] q_d;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  weight_store_n #(
    .FILENAME (""), .DATA_LEN (DL), .N_WORDS (SN),
    .N_LAYERS (5), .ROM_LAT (SLAT), .ADDR_W (5)
  ) u_small (
    .clk (clk), .rst_n (rst_n), .cs (cs_s), .reload (reload_s),
    .busy (busy_s), .valid (valid_s), .q (q_s)
  );

  weight_store_n #(
    .FILENAME (""), .DATA_LEN (DL)
  ) u_def (
    .clk (clk), .rst_n (rst_n), .cs (cs_d), .reload (reload_d),
    .busy (busy_d), .valid (valid_d), .q (q_d)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges from the current point until valid is seen, bounded by max_n.
  task automatic wait_valid_s(output int n);
    n = 0;
    while (!valid_s && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic wait_valid_d(output int n);
    n = 0;
    while (!valid_d && n < 400) begin
      step();
      n++;
    end
  endtask

  task automatic check_slice_s(input string name, input int base);
    for (int i = 0; i < SN; i++) begin
      check(name, q_s[i*DL +: DL], base + i);
    end
  endtask

  typedef struct {
    logic [3:0] cs;
    logic       ok;
    int         base;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n;

    vecs[0] = '{ST_LAYER0, 1'b1, 0};
    vecs[1] = '{ST_LAYER1, 1'b1, 4};
    vecs[2] = '{ST_AFFINE, 1'b1, 16};
    vecs[3] = '{4'hF,      1'b0, 0};
    vecs[4] = '{ST_LAYER2, 1'b1, 8};
    vecs[5] = '{ST_LAYER3, 1'b1, 12};

    rst_n = 1'b0; cs_s = ST_IDLE; cs_d = ST_IDLE; reload_s = 1'b0; reload_d = 1'b0;
    #12;
    check("reset_busy", busy_s, 0);
    check("reset_valid", valid_s, 0);
    check("reset_busy_def", busy_d, 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("idle_after_reset_busy", busy_s, 0);
    check("idle_after_reset_valid", valid_s, 0);

    // ---- Default geometry: AFFINE slice, full-length latency ----
    cs_d = ST_AFFINE;
    step();
    check("def_busy_at_k", busy_d, 1);
    wait_valid_d(n);
    check("def_latency", n + 0, D_LATENCY);
    check("def_busy_done", busy_d, 0);
    check("def_word0", q_d[0*DL +: DL], 1152);
    check("def_word100", q_d[100*DL +: DL], 1252);
    check("def_word287", q_d[287*DL +: DL], 1439);

    // ---- Table of layer codes on the small instance ----
    for (int v = 0; v < 6; v++) begin
      cs_s = vecs[v].cs;
      step();
      check("tbl_busy_at_k", busy_s, vecs[v].ok);
      check("tbl_valid_at_k", valid_s, 0);
      if (vecs[v].ok) begin
        wait_valid_s(n);
        check("tbl_latency", n, S_LATENCY);
        check("tbl_busy_done", busy_s, 0);
        check_slice_s("tbl_word", vecs[v].base);
      end else begin
        step(); step(); step();
        check("tbl_invalid_busy", busy_s, 0);
        check("tbl_invalid_valid", valid_s, 0);
      end
    end

    // ---- Abort: LAYER0 at k, LAYER2 at k+3 -> valid at k+9, slice 2 ----
    cs_s = ST_LAYER0;
    step();                     // edge k
    step(); step();             // k+2
    check("abort_busy_mid", busy_s, 1);
    cs_s = ST_LAYER2;
    step();                     // k+3
    check("abort_valid_at_restart", valid_s, 0);
    check("abort_busy_at_restart", busy_s, 1);
    wait_valid_s(n);
    check("abort_latency", n, S_LATENCY);
    check_slice_s("abort_word", 8);

    // ---- Reload in DONE: drop then refill with identical contents ----
    reload_s = 1'b1;
    step();
    reload_s = 1'b0;
    check("reload_valid_drop", valid_s, 0);
    check("reload_busy", busy_s, 1);
    wait_valid_s(n);
    check("reload_latency", n, S_LATENCY);
    check_slice_s("reload_word", 8);

    // ---- Reload together with cs change: one fill for the new layer ----
    cs_s = ST_LAYER3;
    reload_s = 1'b1;
    step();
    reload_s = 1'b0;
    check("dual_busy", busy_s, 1);
    wait_valid_s(n);
    check("dual_latency", n, S_LATENCY);
    check_slice_s("dual_word", 12);
    for (int i = 0; i < 8; i++) step();
    check("dual_single_fill_valid", valid_s, 1);
    check("dual_single_fill_busy", busy_s, 0);

    // ---- Trigger on the completion edge keeps valid low ----
    cs_s = ST_LAYER0;
    step();                     // edge k
    for (int i = 0; i < S_LATENCY - 1; i++) step();   // k+5
    check("compl_valid_before", valid_s, 0);
    reload_s = 1'b1;
    step();                     // k+6, completion edge
    reload_s = 1'b0;
    check("compl_valid_suppressed", valid_s, 0);
    check("compl_busy_restart", busy_s, 1);
    wait_valid_s(n);
    check("compl_latency", n, S_LATENCY);
    check_slice_s("compl_word", 0);

    // ---- Asynchronous reset 100 cycles into a default fill ----
    cs_d = ST_LAYER0;
    step();
    for (int i = 0; i < 100; i++) step();
    check("rst_mid_busy_before", busy_d, 1);
    #1;
    rst_n = 1'b0;
    cs_d = ST_IDLE;
    cs_s = ST_IDLE;
    #1;
    check("rst_async_busy_def", busy_d, 0);
    check("rst_async_valid_def", valid_d, 0);
    check("rst_async_valid_small", valid_s, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("post_rst_busy_def", busy_d, 0);
    check("post_rst_valid_def", valid_d, 0);
    check("post_rst_busy_small", busy_s, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_store_n.md
Name: weight_store_n

Overview:
- Parametrised successor of the single-bank weight store.
- On a layer-state change, or on an explicit reload, it streams one layer's weight slice from a synchronous weight ROM into a flat register bank. It then presents the bank to the conv/affine datapath as one wide bus.
- Generalised over word count, data width, layer count and ROM read latency.
- Adds asynchronous reset, abort/restart on a mid-load state change, a defined idle for unknown states, and a busy/valid handshake.

Parameters:
- FILENAME, "../data/data18/weight18_0.txt", ROM init file passed to the ROM sub-module.
- DATA_LEN, `data_len, bits per weight word.
- N_WORDS, 288, words per layer slice; this is also the bank depth.
- N_LAYERS, 5, number of layer slices stored back-to-back in the ROM.
- ROM_LAT, 1, ROM read latency in cycles (≥1).
- ADDR_W, 11, ROM address width; must satisfy 2^ADDR_W ≥ N_LAYERS*N_WORDS.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cs  in  4  current layer state code (`LAYER0..`LAYER3, `AFFINE, others).
- reload  in  1  single-cycle pulse; re-fetches the current layer slice.
- busy  out  1  high while a fill is in progress.
- valid  out  1  high when q holds the complete slice for the current cs.
- q  out  N_WORDS*DATA_LEN  flat bank; word i occupies q[i*DATA_LEN +: DATA_LEN].

Behaviour:
- Reset (rst_n=0, asynchronous):
  - valid=0, busy=0, FSM=IDLE.
  - cs_d=`IDLE-equivalent code 0, addr=0, issue/write counters=0, latency pipe cleared.
  - Bank contents are not reset (they are don't-care while valid=0).
- Layer index: cs→layer mapping is `LAYER0..3 → 0..3 and `AFFINE → 4. Any other code is invalid. Base address = layer*N_WORDS.
- Trigger: at a rising edge where (cs != cs_d) or reload=1. cs_d <= cs on every edge.
- FSM states: IDLE, FILL, DONE.
  - Trigger with a valid code, from any state: enter FILL; addr<=base; issue_cnt<=0; write index<=0; valid<=0; busy<=1; in-flight pipe flushed.
  - Trigger with an invalid code: enter IDLE; valid<=0; busy<=0; ROM address held. No X is ever driven.
  - FILL issue phase: one address per cycle, addr increments for N_WORDS cycles, then issuing stops. The address never crosses into the next slice.
  - Write phase: a ROM_LAT-deep shift register of issue strobes. When its output is set, bank[wr_idx]<=romout and wr_idx increments.
  - FILL→DONE on the edge that writes word N_WORDS-1. That same edge sets valid<=1 and busy<=0.
  - DONE holds until the next trigger. The bank is not written in IDLE or DONE.
- Latency: trigger at edge k.
  - Word i is written at edge k+1+ROM_LAT+i.
  - valid rises at edge k+ROM_LAT+N_WORDS.
  - With defaults, that is k+289.
- Simultaneous events:
  - A trigger during FILL aborts the fill and restarts it, with no stale write from the flushed pipe.
  - A trigger on the same edge as completion wins: valid stays 0.
  - reload together with a cs change is a single trigger.
- The q bus is directly the bank registers, with no output register. The bank is stable whenever valid=1.

Decomposition:
- Shared include/package: the state codes (`LAYER0..`AFFINE, existing state_layer_data.v), `data_len (num_data.v), and a cs→layer-index function/macro with an invalid flag.
- One sub-module: w_rom_n (synchronous ROM, parameters FILENAME, DATA_LEN, ADDR_W, ROM_LAT; ports clk, addr, q).
- This block contains the FSM, counters, latency pipe and bank.

Test Plan:
- Reset mid-fill: assert rst_n=0 at cycle 100 of a fill → valid=0 and busy=0 immediately, without waiting for a clock edge. After release, no bank writes occur until a trigger.
- Basic fill: N_WORDS=4, ROM_LAT=2, ROM[a]=a, cs 0→`LAYER1 at edge k.
  - busy=1 from k.
  - valid=1 at k+6.
  - q words = 4,5,6,7.
- Default parameters: cs=`AFFINE, ROM[a]=a → valid at k+289, word 0=1152, word 287=1439.
- Abort: N_WORDS=4, ROM_LAT=2; `LAYER0 trigger at k, then `LAYER2 at k+3.
  - valid=0 until k+9.
  - q=8..11, with no words from slice 0.
- Reload and invalid cs:
  - reload pulse in DONE → valid drops next edge, then returns after N_WORDS+ROM_LAT cycles with identical q.
  - cs=4'hF → valid=0, busy=0, and the FSM stays in IDLE.
- Reload with simultaneous cs change: exactly one fill occurs, for the new layer. Also check that a trigger on the completion edge leaves valid=0.
